fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Instruction fetch stage: the initiator side of the decode stage's enable/done
//   handshake. On a fetch request it reads one 32-bit instruction from
//   synchronous instruction memory and presents {pc, command} to decode with a
//   one-cycle enable pulse. It then holds command stable until decode returns
//   done, and reports completion to the core controller. Non-pipelined: one
//   instruction in flight.
// PARAMETERS
//   IMEM_LATENCY  2             cycles from imem_addr change to valid imem_data (>=1)
//   RESET_PC      32'h00000000  value driven on imem_addr and dec_pc during reset
// PORTS
//   clk          in   1   clock, rising edge
//   rstn         in   1   reset, asynchronous, active-low
//   enable       in   1   fetch request; sampled only in IDLE
//   pc_in        in   32  byte address to fetch; sampled with enable
//   imem_addr    out  32  instruction memory byte address (registered)
//   imem_data    in   32  instruction word, valid IMEM_LATENCY cycles after imem_addr
//   dec_enable   out  1   one-cycle pulse to decode
//   dec_pc       out  32  pc of the dispatched instruction
//   dec_command  out  32  dispatched instruction word
//   dec_done     in   1   decode completion pulse
//   done         out  1   one-cycle pulse: instruction accepted by decode
//   busy         out  1   high whenever state != IDLE
//   inst_count   out  32  instructions completed since reset; wraps 2^32-1 -> 0
//   misalign     out  1   sticky alignment error (FETCH_ALIGN_CHECK_EN only; else tied 0)
// BEHAVIOUR
//   - Reset (async, rstn=0): state=IDLE; imem_addr=dec_pc=RESET_PC;
//     dec_command=0; dec_enable=done=misalign=0; inst_count=0; wait counter=0.
//     Any in-flight fetch is abandoned. No done is issued for it.
//   - FSM: IDLE -> WAIT -> HOLD -> IDLE (plus ERROR under the macro).
//   - IDLE: on the edge E0 where enable=1: imem_addr<=pc_in, dec_pc<=pc_in,
//     cnt<=1, go to WAIT. enable=0 leaves all registers unchanged.
//   - WAIT: cnt increments each edge. At edge E0+IMEM_LATENCY:
//     dec_command<=imem_data, dec_enable<=1, go to HOLD.
//   - HOLD: dec_enable cleared on the next edge (exactly one cycle high).
//     dec_pc and dec_command are held stable until dec_done is sampled, because
//     decode reads command again in its second cycle.
//     On the edge sampling dec_done=1: done<=1 for one cycle,
//     inst_count<=inst_count+1, go to IDLE.
//     dec_done arriving in the same cycle dec_enable is high is legal and completes.
//   - dec_done outside HOLD: ignored.
//   - enable while busy: ignored; no queueing.
//     enable in the cycle done is high is accepted (state is already IDLE).
//   - Minimum request-to-done latency with a 2-cycle decoder: IMEM_LATENCY+3 cycles.
//   - imem_addr is held after the fetch; memory may be re-read harmlessly.
// CONFIGURATION
//   FETCH_ALIGN_CHECK_EN defined:
//     - In IDLE, enable with pc_in[1:0]!=0 performs no memory access and no dec_enable.
//     - It sets misalign=1, dec_pc<=pc_in, and goes to ERROR.
//     - ERROR holds busy=1 and ignores all inputs; exit is by reset only.
//   FETCH_ALIGN_CHECK_EN not defined:
//     - pc_in[1:0] are forced to 0 on imem_addr and dec_pc.
//     - There is no ERROR state, and misalign is constant 0.
// TESTING
//   1 reset mid-HOLD -> all outputs to reset values immediately (before next edge);
//     no done pulse.
//   2 enable, pc_in=0x100, IMEM_LATENCY=2, mem[0x100]=0x20010005
//     -> dec_enable 1 cycle at E0+2; dec_pc=0x100, dec_command=0x20010005.
//     With a 2-cycle decode model: done pulse, inst_count=1, busy=0.
//   3 dec_done withheld 10 cycles -> dec_command/dec_pc unchanged throughout;
//     dec_enable high exactly 1 cycle.
//   4 enable pulses at 0x200 during WAIT and HOLD -> ignored; next dec_pc is the
//     original pc. Back-to-back enable in the done cycle accepted.
//   5 preload inst_count=0xFFFFFFFF via force, complete one fetch -> inst_count=0.
//   6 pc_in=0x102: with macro -> misalign=1, busy stuck 1, no dec_enable;
//     without -> fetch at 0x100, dec_pc=0x100.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage, initiator of the decode enable/done
// handshake. One instruction in flight: IDLE -> WAIT -> HOLD -> IDLE.
// Optional build macro FETCH_ALIGN_CHECK_EN: misaligned fetch requests trap into
// a sticky ERROR state (left only by reset) and raise misalign. Without it the
// low two pc bits are dropped and misalign is tied low.
module fetch_unit #(
    parameter int unsigned IMEM_LATENCY = 2,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    input  logic [31:0] pc_in,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        dec_enable,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_command,
    input  logic        dec_done,
    output logic        done,
    output logic        busy,
    output logic [31:0] inst_count,
    output logic        misalign
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] ERROR = 2'd3;

    // Wait counter only has to reach IMEM_LATENCY.
    localparam int CNT_W = $clog2(IMEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IMEM_LATENCY);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      inst_count_q;
    logic [31:0]      fetch_pc;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_q;
    // Misaligned requests never reach memory, so the pc is used as given.
    assign fetch_pc = pc_in;
    assign misalign = misalign_q;
`else
    // Word-align the request; the low bits are simply ignored.
    assign fetch_pc = pc_in & ~32'h0000_0003;
    assign misalign = 1'b0;
`endif

    assign busy       = (state != IDLE);
    assign inst_count = inst_count_q;

    // Fetch FSM with its datapath registers; pulses default low each edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            cnt          <= '0;
            imem_addr    <= RESET_PC;
            dec_pc       <= RESET_PC;
            dec_command  <= 32'h0;
            dec_enable   <= 1'b0;
            done         <= 1'b0;
            inst_count_q <= 32'h0;
`ifdef FETCH_ALIGN_CHECK_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch below
            // sees the pre-edge register values and the defaults here are
            // overridden cleanly by the later assignments in the same edge.
            dec_enable <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
`ifdef FETCH_ALIGN_CHECK_EN
                        if (pc_in[1:0] != 2'b00) begin
                            misalign_q <= 1'b1;
                            dec_pc     <= pc_in;
                            state      <= ERROR;
                        end else begin
                            imem_addr <= fetch_pc;
                            dec_pc    <= fetch_pc;
                            cnt       <= CNT_W'(1);
                            state     <= WAIT;
                        end
`else
                        imem_addr <= fetch_pc;
                        dec_pc    <= fetch_pc;
                        cnt       <= CNT_W'(1);
                        state     <= WAIT;
`endif
                    end
                end
                WAIT: begin
                    // cnt equals the number of edges since the request edge.
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        dec_command <= imem_data;
                        dec_enable  <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    // dec_pc/dec_command stay put: decode re-reads them.
                    if (dec_done) begin
                        done         <= 1'b1;
                        inst_count_q <= inst_count_q + 32'd1;
                        state        <= IDLE;
                    end
                end
                default: begin
`ifdef FETCH_ALIGN_CHECK_EN
                    // ERROR: sticky, all inputs ignored until reset.
                    state <= ERROR;
`else
                    // ERROR does not exist in this build; recover if ever hit.
                    state <= IDLE;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- directed bench for fetch_unit with a 2-cycle memory model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic [31:0] pc_in;
    logic [31:0] imem_addr;
    logic [31:0] imem_data = 32'h0;
    logic        dec_enable;
    logic [31:0] dec_pc;
    logic [31:0] dec_command;
    logic        dec_done;
    logic        done;
    logic        busy;
    logic [31:0] inst_count;
    logic        misalign;

    int n_vec = 0;
    int n_err = 0;
    int en_high;

    fetch_unit #(.IMEM_LATENCY(2), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .enable      (enable),
        .pc_in       (pc_in),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .dec_enable  (dec_enable),
        .dec_pc      (dec_pc),
        .dec_command (dec_command),
        .dec_done    (dec_done),
        .done        (done),
        .busy        (busy),
        .inst_count  (inst_count),
        .misalign    (misalign)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0100: mem_word = 32'h2001_0005;
            32'h0000_0200: mem_word = 32'hDEAD_BEEF;
            32'h0000_0300: mem_word = 32'h8C22_0004;
            default:       mem_word = 32'hA5A5_0000 ^ a;
        endcase
    endfunction

    // Synchronous memory: data for an address is sampleable 2 edges later.
    always @(posedge clk) imem_data <= mem_word(imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        rstn = 1'b1; enable = 1'b0; pc_in = 32'h0; dec_done = 1'b0;

        // Reset state
        #2 rstn = 1'b0;
        #1;
        check("rst_busy",  {31'h0, busy}, 32'h0);
        check("rst_addr",  imem_addr, 32'h0);
        check("rst_pc",    dec_pc, 32'h0);
        check("rst_cmd",   dec_command, 32'h0);
        check("rst_en",    {31'h0, dec_enable}, 32'h0);
        check("rst_done",  {31'h0, done}, 32'h0);
        check("rst_count", inst_count, 32'h0);
        check("rst_mis",   {31'h0, misalign}, 32'h0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Basic fetch at 0x100 with a 2-cycle decoder
        @(negedge clk); enable = 1'b1; pc_in = 32'h100;
        @(negedge clk); enable = 1'b0;
        check("t2_busy", {31'h0, busy}, 32'h1);
        check("t2_addr", imem_addr, 32'h100);
        check("t2_en0",  {31'h0, dec_enable}, 32'h0);
        @(negedge clk);
        check("t2_en1",  {31'h0, dec_enable}, 32'h0);
        @(negedge clk);
        check("t2_en2",  {31'h0, dec_enable}, 32'h1);
        check("t2_pc",   dec_pc, 32'h100);
        check("t2_cmd",  dec_command, 32'h2001_0005);
        @(negedge clk); dec_done = 1'b1;
        check("t2_en3",  {31'h0, dec_enable}, 32'h0);
        check("t2_nodone", {31'h0, done}, 32'h0);
        @(negedge clk); dec_done = 1'b0;
        check("t2_done",  {31'h0, done}, 32'h1);
        check("t2_count", inst_count, 32'h1);
        check("t2_idle",  {31'h0, busy}, 32'h0);
        @(negedge clk);
        check("t2_done_clr", {31'h0, done}, 32'h0);

        // dec_done withheld 10 cycles: outputs stable, enable one cycle
        @(negedge clk); enable = 1'b1; pc_in = 32'h300;
        @(negedge clk); enable = 1'b0; pc_in = 32'h0;
        en_high = 0;
        @(negedge clk);
        if (dec_enable) en_high++;
        @(negedge clk);
        if (dec_enable) en_high++;
        check("t3_cmd0", dec_command, 32'h8C22_0004);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dec_enable) en_high++;
            check("t3_cmd_hold", dec_command, 32'h8C22_0004);
            check("t3_pc_hold",  dec_pc, 32'h300);
            check("t3_busy",     {31'h0, busy}, 32'h1);
        end
        check("t3_en_cycles", en_high, 32'd1);
        dec_done = 1'b1;
        @(negedge clk); dec_done = 1'b0;
        check("t3_done",  {31'h0, done}, 32'h1);
        check("t3_count", inst_count, 32'h2);

        // enable ignored while busy; back-to-back enable in the done cycle
        @(negedge clk); enable = 1'b1; pc_in = 32'h100;
        @(negedge clk); enable = 1'b1; pc_in = 32'h200;
        @(negedge clk); enable = 1'b0;
        check("t4_addr_wait", imem_addr, 32'h100);
        @(negedge clk); enable = 1'b1; pc_in = 32'h200;
        check("t4_en",  {31'h0, dec_enable}, 32'h1);
        check("t4_pc",  dec_pc, 32'h100);
        check("t4_cmd", dec_command, 32'h2001_0005);
        @(negedge clk); dec_done = 1'b1;
        check("t4_pc_hold", dec_pc, 32'h100);
        @(negedge clk); dec_done = 1'b0; enable = 1'b1; pc_in = 32'h300;
        check("t4_done",  {31'h0, done}, 32'h1);
        check("t4_pc_after", dec_pc, 32'h100);
        check("t4_count", inst_count, 32'h3);
        @(negedge clk); enable = 1'b0;
        check("t4_b2b_busy", {31'h0, busy}, 32'h1);
        check("t4_b2b_addr", imem_addr, 32'h300);
        check("t4_b2b_pc",   dec_pc, 32'h300);
        @(negedge clk);
        @(negedge clk); dec_done = 1'b1;
        check("t4_b2b_en",  {31'h0, dec_enable}, 32'h1);
        check("t4_b2b_cmd", dec_command, 32'h8C22_0004);
        @(negedge clk); dec_done = 1'b0;
        check("t4_b2b_done",  {31'h0, done}, 32'h1);
        check("t4_b2b_count", inst_count, 32'h4);

        // inst_count wrap
        @(negedge clk);
        force dut.inst_count_q = 32'hFFFF_FFFF;
        #1 release dut.inst_count_q;
        check("t5_preload", inst_count, 32'hFFFF_FFFF);
        @(negedge clk); enable = 1'b1; pc_in = 32'h100;
        @(negedge clk); enable = 1'b0;
        @(negedge clk);
        @(negedge clk); dec_done = 1'b1;
        check("t5_en", {31'h0, dec_enable}, 32'h1);
        @(negedge clk); dec_done = 1'b0;
        check("t5_done", {31'h0, done}, 32'h1);
        check("t5_wrap", inst_count, 32'h0);

        // Reset mid-HOLD: immediate reset values, no done pulse afterwards
        @(negedge clk); enable = 1'b1; pc_in = 32'h200;
        @(negedge clk); enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t1_en", {31'h0, dec_enable}, 32'h1);
        @(negedge clk);
        check("t1_hold", dec_command, 32'hDEAD_BEEF);
        #2 rstn = 1'b0; dec_done = 1'b1;
        #1;
        check("t1_busy",  {31'h0, busy}, 32'h0);
        check("t1_addr",  imem_addr, 32'h0);
        check("t1_pc",    dec_pc, 32'h0);
        check("t1_cmd",   dec_command, 32'h0);
        check("t1_en0",   {31'h0, dec_enable}, 32'h0);
        check("t1_done0", {31'h0, done}, 32'h0);
        check("t1_count", inst_count, 32'h0);
        @(negedge clk); rstn = 1'b1;
        @(negedge clk); dec_done = 1'b0;
        check("t1_nodone", {31'h0, done}, 32'h0);
        check("t1_idle",   {31'h0, busy}, 32'h0);
        check("t1_count2", inst_count, 32'h0);

        // Misaligned request at 0x102
        @(negedge clk); enable = 1'b1; pc_in = 32'h102;
        @(negedge clk); enable = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        check("t6_mis",  {31'h0, misalign}, 32'h1);
        check("t6_pc",   dec_pc, 32'h102);
        check("t6_addr", imem_addr, 32'h0);
        for (int i = 0; i < 4; i++) begin
            enable = 1'b1; pc_in = 32'h100; dec_done = 1'b1;
            @(negedge clk);
            check("t6_stuck_busy", {31'h0, busy}, 32'h1);
            check("t6_no_en",      {31'h0, dec_enable}, 32'h0);
            check("t6_no_done",    {31'h0, done}, 32'h0);
        end
        enable = 1'b0; dec_done = 1'b0;
        check("t6_mis_sticky", {31'h0, misalign}, 32'h1);
`else
        check("t6_addr", imem_addr, 32'h100);
        check("t6_pc",   dec_pc, 32'h100);
        check("t6_busy", {31'h0, busy}, 32'h1);
        @(negedge clk);
        @(negedge clk); dec_done = 1'b1;
        check("t6_en",  {31'h0, dec_enable}, 32'h1);
        check("t6_cmd", dec_command, 32'h2001_0005);
        check("t6_mis", {31'h0, misalign}, 32'h0);
        @(negedge clk); dec_done = 1'b0;
        check("t6_done",  {31'h0, done}, 32'h1);
        check("t6_count", inst_count, 32'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
